// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch stage's upstream, downstream and memory-port signals.
//   master modport: fetch stage side (accepts PC, drives memory request and output word)
//   slave modport : environment side (PC source, downstream consumer, memory controller)
//   fetch_fault exists only when FETCH_TIMEOUT_EN is defined.
interface fetch_if;
  logic        DIR;
  logic [31:0] data_in;
  logic        ack_out;
  logic        DOR;
  logic [31:0] data_out;
  logic        ack_in;
  logic        mem_en;
  logic        mem_burst_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_di;
  logic        mem_do_ack;
  logic [31:0] mem_do;
  logic [15:0] fetch_count;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_fault;
`endif
  modport master (
    input  DIR, data_in, ack_in, mem_do_ack, mem_do,
    output ack_out, DOR, data_out, mem_en, mem_burst_en, mem_we, mem_addr, mem_di, fetch_count
`ifdef FETCH_TIMEOUT_EN
    , output fetch_fault
`endif
  );
  modport slave (
    output DIR, data_in, ack_in, mem_do_ack, mem_do,
    input  ack_out, DOR, data_out, mem_en, mem_burst_en, mem_we, mem_addr, mem_di, fetch_count
`ifdef FETCH_TIMEOUT_EN
    , input fetch_fault
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: single-entry instruction fetch; accepts a byte PC, reads one word, offers it downstream.
//   clk   : system clock, posedge
//   reset : synchronous, active-low
//   bus   : fetch_if.master (DIR/data_in/ack_out upstream, DOR/data_out/ack_in downstream,
//           mem_* read-only device port, fetch_count completed fetches)
//   Optional FETCH_TIMEOUT_EN: MEM_REQ watchdog of TIMEOUT_CYCLES, adds fetch_fault.
module fetch_stage #(
  parameter int ADDR_LSB       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, MEM_REQ, OUT_VALID} state_t;
  state_t state;
  logic   armed;
  logic   unused_data_in;
  assign unused_data_in   = ^bus.data_in;
  assign bus.mem_burst_en = 1'b0;
  assign bus.mem_we       = 1'b0;
  assign bus.mem_di       = '0;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic          expired;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      armed           <= 1'b1;
      bus.ack_out     <= 1'b0;
      bus.DOR         <= 1'b0;
      bus.data_out    <= '0;
      bus.mem_en      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.fetch_count <= '0;
`ifdef FETCH_TIMEOUT_EN
      bus.fetch_fault <= 1'b0;
      cnt             <= '0;
`endif
    end else begin
      bus.ack_out <= 1'b0;
      // upstream only drops DIR after seeing ack_out, so a low DIR re-arms acceptance
      if (!bus.DIR) armed <= 1'b1;
      case (state)
        IDLE: if (bus.DIR && armed) begin
          bus.mem_addr <= bus.data_in[ADDR_LSB+15:ADDR_LSB];
          bus.ack_out  <= 1'b1;
          bus.mem_en   <= 1'b1;
          armed        <= 1'b0;
          state        <= MEM_REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt          <= '0;
`endif
        end
        MEM_REQ: if (bus.mem_do_ack) begin
          bus.data_out    <= bus.mem_do;
          bus.mem_en      <= 1'b0;
          bus.DOR         <= 1'b1;
          bus.fetch_count <= bus.fetch_count + 16'd1;
          state           <= OUT_VALID;
`ifdef FETCH_TIMEOUT_EN
        end else if (expired) begin
          bus.data_out    <= 32'hDEADBEEF;
          bus.mem_en      <= 1'b0;
          bus.DOR         <= 1'b1;
          bus.fetch_fault <= 1'b1;
          state           <= OUT_VALID;
        end else begin
          cnt <= cnt + 1'b1;
`endif
        end
        OUT_VALID: if (bus.ack_in) begin
          bus.DOR <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
          bus.fetch_fault <= 1'b0;
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + randomized self-checking bench for fetch_stage against a memory/count model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_count = 0;
  fetch_if bus ();
  fetch_stage #(.ADDR_LSB(2), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return a == 16'd2 ? 32'h1234_5678 : {a * 16'd40503, ~a};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_accept(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ack_out;
    end
  endtask
  task automatic mem_respond();
    bus.mem_do_ack = 1'b1;
    bus.mem_do = mem_word(bus.mem_addr);
    @(negedge clk);
    bus.mem_do_ack = 1'b0;
    bus.mem_do = $urandom;
  endtask
  task automatic fetch(input logic [31:0] pc, input int lat, input int hold, input int dwait);
    logic [15:0] a;
    logic [31:0] w;
    int bad;
    bit seen;
    a = pc[17:2];
    w = mem_word(a);
    @(negedge clk);
    bus.DIR = 1'b1;
    bus.data_in = pc;
    wait_accept(seen);
    check("accept", 32'(seen), 1);
    check("mem_en_on", 32'(bus.mem_en), 1);
    check("mem_addr", 32'(bus.mem_addr), 32'(a));
    check("mem_we", 32'(bus.mem_we), 0);
    check("mem_burst_en", 32'(bus.mem_burst_en), 0);
    bad = 0;
    for (int i = 0; i < lat; i++) begin
      bus.DIR = i < hold;
      @(negedge clk);
      bad += int'(bus.ack_out) + int'(!bus.mem_en) + int'(bus.DOR);
    end
    check("mem_req_hold", 32'(bad), 0);
    bus.DIR = 1'b0;
    mem_respond();
    exp_count++;
    check("dor_rise", 32'(bus.DOR), 1);
    check("data_out", bus.data_out, w);
    check("mem_en_off", 32'(bus.mem_en), 0);
    check("fetch_count", 32'(bus.fetch_count), 32'(16'(exp_count)));
    bad = 0;
    for (int i = 0; i < dwait; i++) begin
      @(negedge clk);
      bad += int'(!bus.DOR) + int'(bus.data_out !== w) + int'(bus.ack_out);
    end
    check("out_hold", 32'(bad), 0);
    bus.ack_in = 1'b1;
    @(negedge clk);
    bus.ack_in = 1'b0;
    check("dor_drop", 32'(bus.DOR), 0);
  endtask
  initial begin
    bit seen;
    int lat;
    bus.DIR = 1'b0;
    bus.data_in = '0;
    bus.ack_in = 1'b0;
    bus.mem_do_ack = 1'b0;
    bus.mem_do = '0;
    repeat (3) @(negedge clk);
    check("rst_ack_out", 32'(bus.ack_out), 0);
    check("rst_dor", 32'(bus.DOR), 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_fetch_count", 32'(bus.fetch_count), 0);
    reset = 1'b1;
    fetch(32'h0000_0008, 3, 0, 0);
    fetch($urandom, 3, 2, 1);
    bus.mem_do_ack = 1'b1;
    bus.mem_do = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_do_ack = 1'b0;
    check("idle_mem_ack_dor", 32'(bus.DOR), 0);
    check("idle_mem_ack_count", 32'(bus.fetch_count), 32'(16'(exp_count)));
    bus.ack_in = 1'b1;
    @(negedge clk);
    bus.ack_in = 1'b0;
    check("idle_ack_in_dor", 32'(bus.DOR), 0);
    check("idle_ack_in_ack_out", 32'(bus.ack_out), 0);
    bus.DIR = 1'b1;
    bus.data_in = 32'h0000_0100;
    wait_accept(seen);
    check("sim_accept1", 32'(seen), 1);
    bus.DIR = 1'b0;
    @(negedge clk);
    mem_respond();
    exp_count++;
    check("sim_dor", 32'(bus.DOR), 1);
    check("sim_data", bus.data_out, mem_word(16'h0040));
    bus.DIR = 1'b1;
    bus.data_in = 32'h0000_0200;
    bus.ack_in = 1'b1;
    @(negedge clk);
    bus.ack_in = 1'b0;
    check("sim_dor_drop", 32'(bus.DOR), 0);
    check("sim_no_accept", 32'(bus.ack_out), 0);
    @(negedge clk);
    check("sim_accept2", 32'(bus.ack_out), 1);
    check("sim_addr2", 32'(bus.mem_addr), 32'h0080);
    bus.DIR = 1'b0;
    mem_respond();
    exp_count++;
    check("sim_data2", bus.data_out, mem_word(16'h0080));
    check("sim_count", 32'(bus.fetch_count), 32'(16'(exp_count)));
    bus.ack_in = 1'b1;
    @(negedge clk);
    bus.ack_in = 1'b0;
    bus.DIR = 1'b1;
    bus.data_in = 32'h0000_0040;
    wait_accept(seen);
    check("rstmid_accept", 32'(seen), 1);
    bus.DIR = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
    check("rstmid_mem_en", 32'(bus.mem_en), 0);
    check("rstmid_dor", 32'(bus.DOR), 0);
    check("rstmid_count", 32'(bus.fetch_count), 0);
    mem_respond();
    @(negedge clk);
    check("late_ack_dor", 32'(bus.DOR), 0);
    check("late_ack_count", 32'(bus.fetch_count), 0);
    for (int n = 0; n < 10; n++) begin
      lat = $urandom_range(0, 4);
      fetch(32'(n * 4), lat, $urandom_range(0, lat < 2 ? lat : 2), $urandom_range(0, 3));
    end
    check("stream_count", 32'(bus.fetch_count), 10);
    repeat (5) fetch($urandom, $urandom_range(0, 4), 0, $urandom_range(0, 2));
`ifdef FETCH_TIMEOUT_EN
    check("rst_fault", 32'(bus.fetch_fault), 0);
    bus.DIR = 1'b1;
    bus.data_in = 32'h0000_0010;
    wait_accept(seen);
    check("to_accept", 32'(seen), 1);
    bus.DIR = 1'b0;
    lat = 0;
    repeat (7) begin
      @(negedge clk);
      lat += int'(bus.DOR);
    end
    check("to_wait", 32'(lat), 0);
    @(negedge clk);
    check("to_dor", 32'(bus.DOR), 1);
    check("to_data", bus.data_out, 32'hDEADBEEF);
    check("to_fault", 32'(bus.fetch_fault), 1);
    check("to_mem_en", 32'(bus.mem_en), 0);
    check("to_count", 32'(bus.fetch_count), 32'(16'(exp_count)));
    bus.ack_in = 1'b1;
    @(negedge clk);
    bus.ack_in = 1'b0;
    check("to_dor_clr", 32'(bus.DOR), 0);
    check("to_fault_clr", 32'(bus.fetch_fault), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage sitting between the PC source and the downstream pipeline.
- Responder side of the DIR/ack input handshake: takes a byte PC and acknowledges it.
- Reads the instruction word through one memory_controller device port (read-only), then offers it downstream via the DOR/ack output handshake.
- Single-entry: one fetch in flight; no new PC accepted until the previous word has been acked downstream.

Parameters:
- ADDR_LSB, 2, PC bit mapped to mem_addr[0]; mem_addr = pc[ADDR_LSB+15:ADDR_LSB].
- TIMEOUT_CYCLES, 64, watchdog limit in cycles, only used with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block.
- DIR  in  1  upstream data-in-ready; data_in valid while high.
- data_in  in  32  byte PC.
- ack_out  out  1  one-cycle acceptance pulse to upstream.
- DOR  out  1  data-out-ready; data_out valid while high.
- data_out  out  32  fetched instruction word.
- ack_in  in  1  downstream acceptance.
- mem_en  out  1  device memory request.
- mem_burst_en  out  1  tied 0.
- mem_we  out  1  tied 0.
- mem_addr  out  16  word address.
- mem_di  out  32  tied 0.
- mem_do_ack  in  1  controller read-complete strobe.
- mem_do  in  32  controller read data, valid when mem_do_ack=1.
- fetch_count  out  16  completed fetches, wraps at 16'hFFFF→0.

Behaviour:
- Reset values: ack_out=0, DOR=0, data_out=0, mem_en=0, mem_addr=0, fetch_count=0, state=IDLE, armed=1.
- Reset mid-operation returns the FSM to IDLE and clears mem_en and DOR on that edge. A late mem_do_ack after reset is ignored.
- The armed flag is cleared when a PC is accepted. It is set at any posedge where DIR=0. Because upstream drops DIR only after seeing ack_out, this flag blocks double-accept of the same PC.
- IDLE: if DIR=1 and armed=1:
  - latch mem_addr from data_in;
  - ack_out=1 for exactly one cycle;
  - mem_en=1 on the same edge;
  - armed=0;
  - go to MEM_REQ.
  Otherwise ack_out=0.
- MEM_REQ: hold mem_en and mem_addr stable until mem_do_ack=1 is sampled. On that edge:
  - data_out<=mem_do;
  - mem_en<=0;
  - DOR<=1;
  - fetch_count<=fetch_count+1;
  - go to OUT_VALID.
  DIR is ignored in this state.
- OUT_VALID: hold DOR and data_out stable until ack_in=1 is sampled. On that edge DOR<=0 and the FSM goes to IDLE. The downstream one-cycle ack pulse therefore drops DOR before the consumer resamples it.
- Latencies:
  - DIR sampled high → ack_out and mem_en high: 1 cycle.
  - mem_do_ack sampled → DOR high: 1 cycle.
  - ack_in sampled → DOR low: 1 cycle.
  - ack_in sampled → earliest next accept (DIR=1 in IDLE): 1 cycle.
- Simultaneous DIR=1 and ack_in=1 in OUT_VALID: only the ack is processed; the PC is accepted in IDLE the next cycle if still presented and armed.
- mem_do_ack while not in MEM_REQ: ignored.
- ack_in while DOR=0: ignored.
- mem_addr truncation: PC bits above ADDR_LSB+15 are dropped silently.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A cycle counter runs in MEM_REQ and resets on entry.
  - If the counter reaches TIMEOUT_CYCLES without mem_do_ack: mem_en<=0, data_out<=32'hDEADBEEF, fetch_fault<=1, DOR<=1, go to OUT_VALID. fetch_count is not incremented.
  - fetch_fault clears with DOR on ack_in.
  - mem_do_ack on the same edge as the timeout wins: a normal completion, no fault.
- Undefined: no counter and no fetch_fault port; MEM_REQ waits indefinitely.

Test Plan:
- Release reset, DIR=1, data_in=32'h0000_0008 → 1 cycle later ack_out pulses 1 cycle, mem_en=1, mem_addr=16'h0002, mem_we=0, mem_burst_en=0.
- In MEM_REQ, mem_do_ack after 3 cycles with mem_do=32'h1234_5678 → next cycle DOR=1, data_out=32'h1234_5678, mem_en=0, fetch_count=1.
- Upstream holds DIR high 2 extra cycles after ack → exactly one accept, one mem_en assertion; no second ack_out until DIR is seen low.
- Downstream pulses ack_in one cycle, PC stream 0,4,8,… for 10 transactions → data_out matches the memory model word by word, no duplicates or drops, fetch_count=10.
- Assert reset (0) while in MEM_REQ, then mem_do_ack arrives after release → mem_en=0 and DOR=0 after the reset edge; the late ack produces no DOR; fetch_count=0.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, never ack memory → after 8 cycles in MEM_REQ: DOR=1, data_out=32'hDEADBEEF, fetch_fault=1; ack_in clears both.
